rr_burst_scheduler: RTL and testbench
=====================================

# rr_burst_scheduler

Round-robin scheduler that shares one burst-capable resource (e.g. the SRAM port) between four requesters. It grants ownership for a whole burst, counts accepted beats, and forcibly releases an owner that reaches the beat quota. It sits between the requester-side request/done lines and the resource's per-beat accept strobe. Grant outputs are fully registered.

## Interface
- MAX_BEATS, default 8: beat quota per grant; legal range 1..255.
- TURNAROUND, default 1: idle cycles between grants; legal values 0 or 1.

- clock  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- request  input  4  bit i high means requester i wants the resource; must stay high until done.
- done  input  4  bit i high marks the last beat of requester i's burst; only meaningful together with beat.
- beat  input  1  the resource accepted one beat from the current owner this cycle.
- grant  output  4  one-hot owner; 4'b0000 when none.
- grant_valid  output  1  OR of grant.
- grant_user  output  2  index of owner; 0 when grant_valid low.
- quota_hit  output  1  one-cycle pulse, registered, asserted the cycle after a quota-forced release.

## Operation
- States: IDLE, BUSY, GAP.
- Internal registers:
  - last_user[1:0]: reset value 3, so requester 0 wins first after reset.
  - beat_cnt[7:0]: reset value 0.
- Pick rule: first requester with request high, searching cyclically from last_user+1 through last_user. The previous owner therefore has the lowest priority.
- IDLE:
  - Outputs are low.
  - If request is nonzero, load the pick into grant, grant_user and last_user, clear beat_cnt, and go to BUSY.
- BUSY:
  - beat increments beat_cnt.
  - The owner is released on the first of these conditions:
    - (a) beat and done[grant_user]: normal end.
    - (b) beat and beat_cnt==MAX_BEATS-1: quota. quota_hit pulses next cycle unless (a) also holds, in which case it counts as a normal end with no pulse.
    - (c) request[grant_user] low: abandon, no beat counted.
  - On release with TURNAROUND=1: grant goes to 0 next cycle and the state goes to GAP.
  - On release with TURNAROUND=0: apply the pick rule in the same cycle. The new owner is registered directly and the state stays BUSY. If request is empty after masking nothing, go to IDLE.
- GAP: outputs low for exactly one cycle, then behave as IDLE (pick if any request, else IDLE).
- Ignored inputs:
  - beat or done while IDLE or GAP.
  - done bits of non-owners.
  - done without beat.
- The quota-released owner may be re-granted immediately if it is the only requester.
- Reset mid-burst: the next cycle shows all outputs 0, state IDLE, last_user=3, beat_cnt=0. No quota_hit.

## Timing
- Reset values: grant=0, grant_valid=0, grant_user=0, quota_hit=0.
- Grant latency: request sampled high in IDLE at edge N gives grant at edge N+1 (1 cycle).
- Release latency: the release condition at edge N gives grant low, or the next owner, at edge N+1.
- Grant-to-grant gap: 1 idle cycle with TURNAROUND=1, 0 with TURNAROUND=0.
- Maximum ownership: MAX_BEATS accepted beats. With continuous beat, that is MAX_BEATS cycles.
- Fairness bound: any continuously requesting user waits at most 3 × (MAX_BEATS + TURNAROUND) cycles plus stall cycles without beat.
- beat_cnt never wraps; it is cleared on each new grant.

## Structure
- Shared package:
  - STATE_IDLE, STATE_BUSY, STATE_GAP encodings.
  - USER_W=2, N_USERS=4.
  - Reset value of last_user.
- One sub-module, rr_pick: combinational. Inputs are request[3:0] and last_user[1:0]; outputs are any and user[1:0]. It implements the cyclic search.
- The top level holds the FSM, beat_cnt, registered outputs and quota_hit.

## Test plan
- Reset, then request=4'b0101 held, with done on the first beat each time: grants go 0, then GAP, then 2, then GAP, then 0, and so on. grant_user is 0 during reset release.
- MAX_BEATS=4, request=4'b0001 held, beat every cycle, done never: owner 0 for 4 cycles, then quota_hit=1 for 1 cycle, then GAP, then re-grant to 0.
- TURNAROUND=0, request=4'b1111, done with every beat: grant_user sequence 0, 1, 2, 3, 0 on consecutive cycles with grant_valid continuously high.
- Owner 1 drops request[1] mid-burst after 2 beats while request[3] is high: the next cycle grant=0 (GAP), then grant=4'b1000. No quota_hit.
- done[2] pulsed while owner is 0, and beat pulsed in IDLE: no state change, beat_cnt unaffected.
- reset asserted at beat 3 of a burst: the next cycle all outputs are 0. After reset release with request=4'b0110, the first grant is user 1.

Source files
------------

// File: rtl/rr_burst_scheduler_pkg.sv
// Shared types and constants for the round-robin burst scheduler.
// Holds the FSM encoding, requester count and the reset owner index.
package rr_burst_scheduler_pkg;

    localparam int USER_W  = 2;
    localparam int N_USERS = 4;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_BUSY = 2'd1,
        STATE_GAP  = 2'd2
    } state_t;

    // Last owner after reset is 3 so that requester 0 is searched first.
    localparam logic [USER_W-1:0] LAST_USER_RESET = 2'd3;

    function automatic logic [N_USERS-1:0] user_onehot(input logic [USER_W-1:0] user);
        logic [N_USERS-1:0] g;
        g       = '0;
        g[user] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/rr_burst_scheduler_rr_pick.sv
// Combinational cyclic search: first active request after last_user,
// wrapping round so that last_user itself is considered last.
module rr_pick
    import rr_burst_scheduler_pkg::*;
(
    input  logic [N_USERS-1:0] request,
    input  logic [USER_W-1:0]  last_user,
    output logic               any,
    output logic [USER_W-1:0]  user
);

    logic [USER_W-1:0] cand [N_USERS];
    logic [N_USERS-1:0] hit;

    // Candidate gi is the user gi+1 positions after the previous owner.
    generate
        for (genvar gi = 0; gi < N_USERS; gi++) begin : g_cand
            assign cand[gi] = last_user + USER_W'(gi + 1);
            assign hit[gi]  = request[cand[gi]];
        end
    endgenerate

    always_comb begin
        any  = |request;
        user = '0;
        for (int k = N_USERS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                user = cand[k];
            end
        end
    end

endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin owner selection for a burst resource shared by four requesters,
// with per-grant beat quota, optional turnaround gap and registered outputs.
module rr_burst_scheduler
    import rr_burst_scheduler_pkg::*;
#(
    parameter int MAX_BEATS  = 8,
    parameter int TURNAROUND = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  request,
    input  logic [3:0]  done,
    input  logic        beat,
    output logic [3:0]  grant,
    output logic        grant_valid,
    output logic [1:0]  grant_user,
    output logic        quota_hit
);

    localparam logic [7:0] QUOTA_LAST = 8'(MAX_BEATS - 1);

    state_t             state_reg;
    logic [USER_W-1:0]  last_user_reg;
    logic [7:0]         beat_cnt_reg;
    logic [N_USERS-1:0] grant_reg;
    logic               grant_valid_reg;
    logic [USER_W-1:0]  grant_user_reg;
    logic               quota_hit_reg;

    logic               pick_any;
    logic [USER_W-1:0]  pick_user;
    logic               owner_done;
    logic               quota_reached;
    logic               abandon;
    logic               release_now;
    logic               load_pick;

    rr_pick u_rr_pick (
        .request   (request),
        .last_user (last_user_reg),
        .any       (pick_any),
        .user      (pick_user)
    );

    // Release causes; order of precedence is normal end, quota, abandon.
    assign owner_done    = beat && done[grant_user_reg];
    assign quota_reached = beat && (beat_cnt_reg == QUOTA_LAST);
    assign abandon       = !request[grant_user_reg];
    assign release_now   = owner_done || quota_reached || abandon;

    // A new owner is loaded from IDLE/GAP, or back-to-back without turnaround.
    always_comb begin
        load_pick = 1'b0;
        if (pick_any) begin
            if (state_reg != STATE_BUSY) begin
                load_pick = 1'b1;
            end else if (release_now && (TURNAROUND == 0)) begin
                load_pick = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= STATE_IDLE;
            last_user_reg   <= LAST_USER_RESET;
            beat_cnt_reg    <= 8'd0;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            grant_user_reg  <= '0;
            quota_hit_reg   <= 1'b0;
        end else begin
            quota_hit_reg <= 1'b0;
            if (load_pick) begin
                state_reg       <= STATE_BUSY;
                last_user_reg   <= pick_user;
                beat_cnt_reg    <= 8'd0;
                grant_reg       <= user_onehot(pick_user);
                grant_valid_reg <= 1'b1;
                grant_user_reg  <= pick_user;
            end
            case (state_reg)
                STATE_IDLE, STATE_GAP: begin
                    if (!load_pick) begin
                        state_reg <= STATE_IDLE;
                    end
                end
                STATE_BUSY: begin
                    if (release_now) begin
                        quota_hit_reg <= quota_reached && !owner_done;
                        if (!load_pick) begin
                            state_reg       <= (TURNAROUND != 0) ? STATE_GAP : STATE_IDLE;
                            grant_reg       <= '0;
                            grant_valid_reg <= 1'b0;
                            grant_user_reg  <= '0;
                        end
                    end else if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg       <= STATE_IDLE;
                    grant_reg       <= '0;
                    grant_valid_reg <= 1'b0;
                    grant_user_reg  <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_user  = grant_user_reg;
    assign quota_hit   = quota_hit_reg;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler: three instances (default, quota of 4,
// no turnaround) share stimulus; each scenario checks the relevant instance.
module tb_rr_burst_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] request;
    logic [3:0] done;
    logic       beat;

    logic [3:0] grant_o       [3];
    logic       grant_valid_o [3];
    logic [1:0] grant_user_o  [3];
    logic       quota_hit_o   [3];

    int n_checks;
    int n_fail;

    rr_burst_scheduler #(.MAX_BEATS(8), .TURNAROUND(1)) dut_default (
        .clock(clock), .reset(reset), .request(request), .done(done), .beat(beat),
        .grant(grant_o[0]), .grant_valid(grant_valid_o[0]),
        .grant_user(grant_user_o[0]), .quota_hit(quota_hit_o[0])
    );

    rr_burst_scheduler #(.MAX_BEATS(4), .TURNAROUND(1)) dut_quota4 (
        .clock(clock), .reset(reset), .request(request), .done(done), .beat(beat),
        .grant(grant_o[1]), .grant_valid(grant_valid_o[1]),
        .grant_user(grant_user_o[1]), .quota_hit(quota_hit_o[1])
    );

    rr_burst_scheduler #(.MAX_BEATS(8), .TURNAROUND(0)) dut_noturn (
        .clock(clock), .reset(reset), .request(request), .done(done), .beat(beat),
        .grant(grant_o[2]), .grant_valid(grant_valid_o[2]),
        .grant_user(grant_user_o[2]), .quota_hit(quota_hit_o[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic expect_out(input int inst, input string tag, input logic [3:0] g,
                              input logic [1:0] u, input logic q);
        $display("[%0t] inst%0d %s grant=%b user=%0d valid=%b quota_hit=%b", $time, inst, tag,
                 grant_o[inst], grant_user_o[inst], grant_valid_o[inst], quota_hit_o[inst]);
        check($sformatf("%s_i%0d_grant", tag, inst), 32'(grant_o[inst]), 32'(g));
        check($sformatf("%s_i%0d_valid", tag, inst), 32'(grant_valid_o[inst]), 32'(|g));
        check($sformatf("%s_i%0d_user", tag, inst), 32'(grant_user_o[inst]), 32'(u));
        check($sformatf("%s_i%0d_quota", tag, inst), 32'(quota_hit_o[inst]), 32'(q));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] req);
        reset   = 1'b1;
        request = req;
        beat    = 1'b0;
        done    = 4'b0000;
        step();
        step();
        for (int i = 0; i < 3; i++) expect_out(i, "reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        request  = 4'b0000;
        done     = 4'b0000;
        beat     = 1'b0;

        // Alternating 0 and 2 with a gap between bursts of one beat.
        apply_reset(4'b0101);
        beat = 1'b1;
        done = 4'b1111;
        step(); expect_out(0, "s1_first", 4'b0001, 2'd0, 1'b0);
        step(); expect_out(0, "s1_gap_a", 4'b0000, 2'd0, 1'b0);
        step(); expect_out(0, "s1_user2", 4'b0100, 2'd2, 1'b0);
        step(); expect_out(0, "s1_gap_b", 4'b0000, 2'd0, 1'b0);
        step(); expect_out(0, "s1_user0", 4'b0001, 2'd0, 1'b0);

        // Quota of 4 with a lone requester and continuous beats.
        apply_reset(4'b0001);
        beat = 1'b1;
        done = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step(); expect_out(1, "s2_own", 4'b0001, 2'd0, 1'b0);
        end
        step(); expect_out(1, "s2_quota", 4'b0000, 2'd0, 1'b1);
        step(); expect_out(1, "s2_regrant", 4'b0001, 2'd0, 1'b0);

        // Back-to-back rotation without turnaround.
        apply_reset(4'b1111);
        beat = 1'b1;
        done = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] u;
            u = 2'(k % 4);
            step(); expect_out(2, "s3_rot", 4'b0001 << u, u, 1'b0);
        end

        // Owner 1 abandons after two beats; user 3 follows after the gap.
        apply_reset(4'b1010);
        step(); expect_out(0, "s4_own1", 4'b0010, 2'd1, 1'b0);
        beat = 1'b1;
        step(); expect_out(0, "s4_beat1", 4'b0010, 2'd1, 1'b0);
        step(); expect_out(0, "s4_beat2", 4'b0010, 2'd1, 1'b0);
        beat    = 1'b0;
        request = 4'b1000;
        step(); expect_out(0, "s4_gap", 4'b0000, 2'd0, 1'b0);
        step(); expect_out(0, "s4_user3", 4'b1000, 2'd3, 1'b0);

        // Beats in IDLE, done without beat and foreign done are all ignored.
        apply_reset(4'b0000);
        beat = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); expect_out(1, "s5_idle_beat", 4'b0000, 2'd0, 1'b0);
        end
        request = 4'b0001;
        beat    = 1'b0;
        done    = 4'b0001;
        step(); expect_out(1, "s5_grant", 4'b0001, 2'd0, 1'b0);
        step(); expect_out(1, "s5_done_nobeat", 4'b0001, 2'd0, 1'b0);
        beat = 1'b1;
        done = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step(); expect_out(1, "s5_foreign_done", 4'b0001, 2'd0, 1'b0);
        end
        step(); expect_out(1, "s5_quota", 4'b0000, 2'd0, 1'b1);

        // Reset at beat 3 of a burst, then restart from requester 1.
        apply_reset(4'b0001);
        beat = 1'b1;
        done = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step(); expect_out(0, "s6_own", 4'b0001, 2'd0, 1'b0);
        end
        reset = 1'b1;
        step();
        expect_out(0, "s6_midreset", 4'b0000, 2'd0, 1'b0);
        expect_out(1, "s6_midreset", 4'b0000, 2'd0, 1'b0);
        reset   = 1'b0;
        request = 4'b0110;
        beat    = 1'b0;
        step(); expect_out(0, "s6_user1", 4'b0010, 2'd1, 1'b0);

        // done on the quota beat is a normal end: no quota pulse.
        apply_reset(4'b0001);
        beat = 1'b1;
        done = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step(); expect_out(1, "s7_own", 4'b0001, 2'd0, 1'b0);
        end
        done = 4'b0001;
        step(); expect_out(1, "s7_done_quota", 4'b0000, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
